clkmon_scan_ctrl: RTL and testbench

//  Time-shares one clkmon frequency monitor across P_NUM_CH clocks through an external clock mux.
//  Per enabled channel it:
//   - selects the channel;
//   - holds the monitor in reset;
//   - waits for a fresh measurement, then samples MON_FREQ (MHz);
//   - checks the sample against per-channel limits.

---
 rtl/clkmon_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_clkmon_scan_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clkmon_scan_ctrl.sv
// ============================================================================
//  Module      : clkmon_scan_ctrl
//  Description : Time-shares one clkmon frequency monitor across P_NUM_CH
//                clocks via an external mux and checks each sample against
//                per-channel limits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkmon_scan_ctrl #(
    parameter int P_NUM_CH     = 4,
    parameter int P_SEL_W      = 2,
    parameter int P_RST_CYC    = 16,
    parameter int P_SETTLE_CYC = 300000000
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    ENABLE,
    input  logic [P_NUM_CH-1:0]     CH_MASK,
    input  logic [16*P_NUM_CH-1:0]  CH_MIN,
    input  logic [16*P_NUM_CH-1:0]  CH_MAX,
    input  logic [15:0]             MON_FREQ,
    output logic [P_SEL_W-1:0]      MON_SEL,
    output logic                    MON_RST,
    output logic [16*P_NUM_CH-1:0]  CH_FREQ,
    output logic [P_NUM_CH-1:0]     CH_VALID,
    output logic [P_NUM_CH-1:0]     CH_ALARM,
    output logic                    ALARM,
    output logic                    SCAN_DONE
);

    localparam int c_SET_W = $clog2(P_SETTLE_CYC + 1);
    localparam int c_RST_W = $clog2(P_RST_CYC + 1);
    localparam int c_CNT_W = (c_SET_W > c_RST_W) ? c_SET_W : c_RST_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_NEXT   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [P_SEL_W-1:0]    r_sel;
    logic [P_SEL_W-1:0]    w_sel_nxt;
    logic                  r_mon_rst;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [15:0]           r_freq [P_NUM_CH];
    logic [15:0]           w_min  [P_NUM_CH];
    logic [15:0]           w_max  [P_NUM_CH];
    logic [P_NUM_CH-1:0]   r_valid;
    logic [P_NUM_CH-1:0]   r_ch_alarm;
    logic                  r_alarm_any;
    logic                  r_done;

    logic [P_SEL_W-1:0]    w_low;
    logic [P_SEL_W-1:0]    w_above;
    logic                  w_above_found;
    logic                  w_any;
    logic                  w_done;
    logic                  w_out_of_range;

    generate
        for (genvar g = 0; g < P_NUM_CH; g++) begin : g_unpack
            assign w_min[g]                = CH_MIN[16*g +: 16];
            assign w_max[g]                = CH_MAX[16*g +: 16];
            assign CH_FREQ[16*g +: 16]     = r_freq[g];
        end
    endgenerate

    assign w_any = |CH_MASK;

    // Lowest set mask bit, and lowest set bit strictly above the current channel.
    always_comb begin
        w_low         = '0;
        w_above       = '0;
        w_above_found = 1'b0;
        for (int k = P_NUM_CH - 1; k >= 0; k--) begin
            if (CH_MASK[k]) begin
                w_low = P_SEL_W'(k);
                if (k > int'(r_sel)) begin
                    w_above       = P_SEL_W'(k);
                    w_above_found = 1'b1;
                end
            end
        end
    end

    assign w_out_of_range = (MON_FREQ == 16'hFFFF) ||
                            (MON_FREQ < w_min[r_sel]) ||
                            (MON_FREQ > w_max[r_sel]);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ENABLE && w_any) begin
                    w_state_nxt = S_RESET;
                    w_sel_nxt   = w_low;
                end
            end
            S_RESET: begin
                if (!ENABLE)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == '0)
                    w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (!ENABLE)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == '0)
                    w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: w_state_nxt = S_NEXT;
            S_NEXT: begin
                w_done = w_any && !w_above_found;
                if (ENABLE && w_any) begin
                    w_state_nxt = S_RESET;
                    w_sel_nxt   = w_above_found ? w_above : w_low;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sel       <= '0;
            r_mon_rst   <= 1'b1;
            r_cnt       <= '0;
            r_valid     <= '0;
            r_ch_alarm  <= '0;
            r_alarm_any <= 1'b0;
            r_done      <= 1'b0;
            for (int k = 0; k < P_NUM_CH; k++)
                r_freq[k] <= 16'hFFFF;
        end else begin
            r_sel       <= w_sel_nxt;
            // Monitor is held in reset whenever the mux may switch or no step is active.
            r_mon_rst   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET);
            r_done      <= w_done;
            r_alarm_any <= |r_ch_alarm;

            if (r_state != S_RESET && w_state_nxt == S_RESET)
                r_cnt <= c_CNT_W'(P_RST_CYC - 1);
            else if (r_state == S_RESET && w_state_nxt == S_SETTLE)
                r_cnt <= c_CNT_W'(P_SETTLE_CYC - 1);
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;

            r_valid    <= r_valid & CH_MASK;
            r_ch_alarm <= r_ch_alarm & CH_MASK;
            // A channel masked mid-step has its result discarded.
            if (r_state == S_SAMPLE && CH_MASK[r_sel]) begin
                r_freq[r_sel]     <= MON_FREQ;
                r_valid[r_sel]    <= 1'b1;
                r_ch_alarm[r_sel] <= w_out_of_range;
            end
        end
    end

    assign MON_SEL   = r_sel;
    assign MON_RST   = r_mon_rst;
    assign CH_VALID  = r_valid;
    assign CH_ALARM  = r_ch_alarm;
    assign ALARM     = r_alarm_any;
    assign SCAN_DONE = r_done;

endmodule

`default_nettype wire

// File: tb/tb_clkmon_scan_ctrl.sv
// ============================================================================
//  Module      : tb_clkmon_scan_ctrl
//  Description : Directed self-checking bench for clkmon_scan_ctrl with a
//                behavioural clkmon (selected channel value, FFFF in reset).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clkmon_scan_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE;
    logic [3:0]  CH_MASK;
    logic [63:0] CH_MIN;
    logic [63:0] CH_MAX;
    logic [15:0] MON_FREQ;
    logic [1:0]  MON_SEL;
    logic        MON_RST;
    logic [63:0] CH_FREQ;
    logic [3:0]  CH_VALID;
    logic [3:0]  CH_ALARM;
    logic        ALARM;
    logic        SCAN_DONE;

    logic [15:0] chval [4];
    int          n_vec;
    int          n_fail;

    clkmon_scan_ctrl #(
        .P_NUM_CH     (4),
        .P_SEL_W      (2),
        .P_RST_CYC    (2),
        .P_SETTLE_CYC (20)
    ) u_dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .CH_MASK   (CH_MASK),
        .CH_MIN    (CH_MIN),
        .CH_MAX    (CH_MAX),
        .MON_FREQ  (MON_FREQ),
        .MON_SEL   (MON_SEL),
        .MON_RST   (MON_RST),
        .CH_FREQ   (CH_FREQ),
        .CH_VALID  (CH_VALID),
        .CH_ALARM  (CH_ALARM),
        .ALARM     (ALARM),
        .SCAN_DONE (SCAN_DONE)
    );

    assign MON_FREQ = MON_RST ? 16'hFFFF : chval[MON_SEL];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   64'(MON_SEL),   64'd0);
        chk({tag, "_rst"},   64'(MON_RST),   64'd1);
        chk({tag, "_freq"},  CH_FREQ,        64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_valid"}, 64'(CH_VALID),  64'd0);
        chk({tag, "_chal"},  64'(CH_ALARM),  64'd0);
        chk({tag, "_alarm"}, 64'(ALARM),     64'd0);
        chk({tag, "_done"},  64'(SCAN_DONE), 64'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        CH_MASK = 4'hF;
        CH_MIN  = {4{16'd90}};
        CH_MAX  = {4{16'd110}};
        for (int i = 0; i < 4; i++) chval[i] = 16'd100;

        #12;
        chk_reset_vals("por");
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        ENABLE  = 1'b1;

        // Full pass, all channels in range
        step(1);   chk("e0_sel", 64'(MON_SEL), 64'd0);
                   chk("e0_rst", 64'(MON_RST), 64'd1);
        step(2);   chk("e2_rst_rel", 64'(MON_RST), 64'd0);
        step(21);  chk("e23_freq0", 64'(CH_FREQ[15:0]), 64'd100);
                   chk("e23_valid", 64'(CH_VALID), 64'h1);
        step(1);   chk("e24_sel", 64'(MON_SEL), 64'd1);
                   chk("e24_rst", 64'(MON_RST), 64'd1);
        step(24);  chk("e48_sel", 64'(MON_SEL), 64'd2);
        step(24);  chk("e72_sel", 64'(MON_SEL), 64'd3);
        chval[1] = 16'd89;
        chval[2] = 16'd120;
        step(24);  chk("e96_done", 64'(SCAN_DONE), 64'd1);
                   chk("e96_sel", 64'(MON_SEL), 64'd0);
                   chk("e96_valid", 64'(CH_VALID), 64'hF);
                   chk("e96_chal", 64'(CH_ALARM), 64'h0);
        step(1);   chk("e97_done", 64'(SCAN_DONE), 64'd0);
                   chk("e97_alarm", 64'(ALARM), 64'd0);
        chval[3] = 16'hFFFF;

        // Out-of-range and dead-clock alarms
        step(46);  chk("e143_chal", 64'(CH_ALARM), 64'h2);
                   chk("e143_alarm", 64'(ALARM), 64'd0);
        step(1);   chk("e144_alarm", 64'(ALARM), 64'd1);
        step(23);  chk("e167_chal", 64'(CH_ALARM), 64'h6);
                   chk("e167_freq2", 64'(CH_FREQ[47:32]), 64'd120);
        step(24);  chk("e191_chal", 64'(CH_ALARM), 64'hE);
                   chk("e191_freq3", 64'(CH_FREQ[63:48]), 64'hFFFF);
        for (int i = 1; i < 4; i++) chval[i] = 16'd100;
        step(96);  chk("e287_chal", 64'(CH_ALARM), 64'h0);
        step(1);   chk("e288_alarm", 64'(ALARM), 64'd0);
                   chk("e288_done", 64'(SCAN_DONE), 64'd1);

        // Mask changes
        CH_MASK = 4'b0101;
        step(1);   chk("e289_valid", 64'(CH_VALID), 64'h5);
        step(23);  chk("e312_sel", 64'(MON_SEL), 64'd2);
        chval[2] = 16'd120;
        step(24);  chk("e336_sel", 64'(MON_SEL), 64'd0);
                   chk("e336_done", 64'(SCAN_DONE), 64'd1);
                   chk("e336_chal", 64'(CH_ALARM), 64'h4);
        CH_MASK = 4'b0001;
        step(1);   chk("e337_valid", 64'(CH_VALID), 64'h1);
                   chk("e337_chal", 64'(CH_ALARM), 64'h0);
        step(23);  chk("e360_done", 64'(SCAN_DONE), 64'd1);
                   chk("e360_sel", 64'(MON_SEL), 64'd0);
        step(1);   chk("e361_done", 64'(SCAN_DONE), 64'd0);
        step(23);  chk("e384_done", 64'(SCAN_DONE), 64'd1);

        // ENABLE dropped mid-SETTLE, then restarted
        step(7);   chk("e391_rst", 64'(MON_RST), 64'd0);
        ENABLE   = 1'b0;
        chval[0] = 16'd50;
        step(1);   chk("e392_rst", 64'(MON_RST), 64'd1);
                   chk("e392_freq0", 64'(CH_FREQ[15:0]), 64'd100);
        step(1);
        ENABLE  = 1'b1;
        CH_MASK = 4'b1100;
        step(1);   chk("e394_sel", 64'(MON_SEL), 64'd2);
                   chk("e394_rst", 64'(MON_RST), 64'd1);
        step(22);  chk("e416_rst", 64'(MON_RST), 64'd0);

        // Asynchronous reset during SAMPLE
        #2 RESET_N = 1'b0;
        #1 chk_reset_vals("async");
        step(2);   chk("hold_sel", 64'(MON_SEL), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
